// File: rtl/evt_agg_pkg.sv
// evt_agg_pkg: shared types and helpers for the event edge aggregator.
//   evt_mode_e  - per-channel detection mode (POS, NEG, ANY edge, LEVEL high)
//   SYNC_MAX    - deepest supported input synchroniser
//   lowest_set  - lowest set bit of a 32-bit vector, with a found flag
package evt_agg_pkg;
    typedef enum logic [1:0] {EVT_POS, EVT_NEG, EVT_ANY, EVT_LEVEL} evt_mode_e;
    localparam int SYNC_MAX = 4;
    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } lowest_t;
    function automatic lowest_t lowest_set(input logic [31:0] v);
        lowest_t r;
        r = '0;
        for (int i = 31; i >= 0; i--)
            if (v[i]) begin
                r.found = 1'b1;
                r.idx   = 5'(i);
            end
        return r;
    endfunction
endpackage

// File: rtl/evt_edge_aggregator_if.sv
// evt_edge_aggregator_if: valid/ready event-ID handout port.
//   evt_valid_o - slot holds an event ID (master drives)
//   evt_id_o    - channel index of the held event (master drives)
//   evt_ready_i - consumer accepts evt_id_o (slave drives)
interface evt_edge_aggregator_if #(parameter int ID_W = 3);
    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [ID_W-1:0] evt_id_o;
    modport master (output evt_valid_o, evt_id_o, input evt_ready_i);
    modport slave  (input evt_valid_o, evt_id_o, output evt_ready_i);
endinterface

// File: rtl/evt_edge_det.sv
// evt_edge_det: one channel of synchroniser, previous sample and mode decode.
//   clk, rst_n - clock, async active-low reset
//   sig_i      - raw channel input
//   mode_i     - detection mode
//   detect_o   - event detected this cycle
module evt_edge_det
    import evt_agg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      sig_i,
    input  evt_mode_e mode_i,
    output logic      detect_o
);
    localparam int SN = SYNC_STAGES > SYNC_MAX ? SYNC_MAX : SYNC_STAGES;
    logic        s;
    logic        p_q;
    // Armed only once the synchroniser and the previous sample both hold
    // post-reset data, so a line already high at reset exit is not an edge.
    logic [SN:0] arm_q;
    if (SN == 0) begin : g_direct
        assign s = sig_i;
    end else begin : g_sync
        logic [SN-1:0] sync_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sync_q <= '0;
            else        sync_q <= SN'({sync_q, sig_i});
        assign s = sync_q[SN-1];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            p_q   <= 1'b0;
            arm_q <= '0;
        end else begin
            p_q   <= s;
            arm_q <= (SN+1)'({arm_q, 1'b1});
        end
    assign detect_o = arm_q[SN] & (mode_i == EVT_POS ? s & ~p_q :
                                   mode_i == EVT_NEG ? ~s & p_q :
                                   mode_i == EVT_ANY ? s ^ p_q : s);
endmodule

// File: rtl/evt_edge_aggregator.sv
// evt_edge_aggregator: multi-channel event capture with sticky pending bits,
// overflow tracking, masked IRQ and a priority-ordered event-ID handout.
//   clk, rst_n - clock, async active-low reset
//   sig_i      - raw event inputs
//   mode_i     - 2-bit mode per channel at [2k+1:2k]
//   mask_i     - excludes channels from irq_o and from handout
//   clr_i      - W1C pulse clearing pend and ovf
//   pend_o     - sticky pending bits
//   ovf_o      - sticky overflow bits
//   irq_o      - registered OR of unmasked pending bits
//   evt        - valid/ready event-ID handout (master side)
module evt_edge_aggregator
    import evt_agg_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        sig_i,
    input  logic [2*N_CH-1:0]      mode_i,
    input  logic [N_CH-1:0]        mask_i,
    input  logic [N_CH-1:0]        clr_i,
    output logic [N_CH-1:0]        pend_o,
    output logic [N_CH-1:0]        ovf_o,
    output logic                   irq_o,
    evt_edge_aggregator_if.master  evt
);
    logic [N_CH-1:0] det;
    logic [N_CH-1:0] cand;
    logic [N_CH-1:0] ho;
    logic            load;
    lowest_t         sel;
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        evt_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_det (
            .clk      (clk),
            .rst_n    (rst_n),
            .sig_i    (sig_i[k]),
            .mode_i   (evt_mode_e'(mode_i[2*k +: 2])),
            .detect_o (det[k])
        );
    end
    assign cand = pend_o & ~mask_i;
    assign sel  = lowest_set(32'(cand));
    // The slot reloads when empty or being accepted; the loaded channel's
    // pend bit is handed out (cleared) in the same cycle.
    assign load = ~evt.evt_valid_o | evt.evt_ready_i;
    assign ho   = (load & sel.found) ? N_CH'(1) << sel.idx : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pend_o          <= '0;
            ovf_o           <= '0;
            irq_o           <= 1'b0;
            evt.evt_valid_o <= 1'b0;
            evt.evt_id_o    <= '0;
        end else begin
            // A new detection beats both clear and handout.
            pend_o <= det | (pend_o & ~clr_i & ~ho);
            ovf_o  <= (det & pend_o & ~ho) | (ovf_o & ~clr_i);
            irq_o  <= |cand;
            if (load) begin
                evt.evt_valid_o <= sel.found;
                if (sel.found) evt.evt_id_o <= sel.idx[ID_W-1:0];
            end
        end
endmodule

// File: tb/tb_evt_edge_aggregator.sv
// tb_evt_edge_aggregator: directed stimulus, per-cycle model comparison and literal checks.
module tb_evt_edge_aggregator;
    localparam int SYNC = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  sig = 8'hFF;
    logic [15:0] mode = '0;
    logic [7:0]  mask = '0;
    logic [7:0]  clr = '0;
    logic [7:0]  pend, ovf;
    logic        irq;
    int          n_cmp = 0;
    int          n_err = 0;
    evt_edge_aggregator_if #(.ID_W(3)) evt_if ();
    evt_edge_aggregator #(.N_CH(8), .SYNC_STAGES(SYNC), .ID_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sig),
        .mode_i (mode),
        .mask_i (mask),
        .clr_i  (clr),
        .pend_o (pend),
        .ovf_o  (ovf),
        .irq_o  (irq),
        .evt    (evt_if)
    );
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: every posedge samples sig; a channel sees an event between two
    // consecutive post-reset samples delayed by the synchroniser depth.
    logic [7:0] smp[$];
    logic [7:0] m_pend = '0, m_ovf = '0;
    logic       m_irq = 1'b0, m_valid = 1'b0;
    logic [2:0] m_id = '0;

    always @(negedge rst_n) begin
        smp.delete();
        m_pend = '0; m_ovf = '0; m_irq = 1'b0; m_valid = 1'b0; m_id = '0;
    end

    always @(posedge clk) begin
        logic [7:0] det, cand, n_pend, n_ovf;
        logic       c, pr;
        int         m, low;
        bit         take, hand;
        if (rst_n) begin
            smp.push_back(sig);
            m = smp.size();
            det = '0;
            if (m - SYNC - 2 >= 0)
                for (int k = 0; k < 8; k++) begin
                    c  = smp[m-1-SYNC][k];
                    pr = smp[m-2-SYNC][k];
                    case (mode[2*k +: 2])
                        2'd0:    det[k] = c && !pr;
                        2'd1:    det[k] = !c && pr;
                        2'd2:    det[k] = c != pr;
                        default: det[k] = c;
                    endcase
                end
            cand = m_pend & ~mask;
            low = -1;
            for (int k = 7; k >= 0; k--) if (cand[k]) low = k;
            take = !m_valid || evt_if.evt_ready_i;
            n_pend = m_pend;
            n_ovf = m_ovf;
            for (int k = 0; k < 8; k++) begin
                hand = take && (low == k);
                if (det[k]) n_pend[k] = 1'b1;
                else if (clr[k] || hand) n_pend[k] = 1'b0;
                if (det[k] && m_pend[k] && !hand) n_ovf[k] = 1'b1;
                else if (clr[k]) n_ovf[k] = 1'b0;
            end
            m_irq = cand != 0;
            if (take) begin
                m_valid = low >= 0;
                if (low >= 0) m_id = 3'(low);
            end
            m_pend = n_pend;
            m_ovf = n_ovf;
        end
    end

    always @(negedge clk) begin
        check("m_pend", pend, m_pend);
        check("m_ovf", ovf, m_ovf);
        check("m_irq", irq, m_irq);
        check("m_valid", evt_if.evt_valid_o, m_valid);
        if (m_valid) check("m_id", evt_if.evt_id_o, m_id);
    end

    initial begin
        evt_if.evt_ready_i = 1'b0;
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_pend", pend, 8'h00);
        check("rst_ovf", ovf, 8'h00);
        check("rst_irq", irq, 0);
        check("rst_valid", evt_if.evt_valid_o, 0);
        check("rst_id", evt_if.evt_id_o, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("arm_pend", pend, 8'h00);
        end
        // ch3 rising edge latency
        sig = 8'hF7; tick(5);
        sig = 8'hFF; tick(2);
        check("lat_pend_early", pend, 8'h00);
        tick(1);
        check("lat_pend", pend, 8'h08);
        check("lat_irq_early", irq, 0);
        tick(1);
        check("lat_irq", irq, 1);
        check("lat_valid", evt_if.evt_valid_o, 1);
        check("lat_id", evt_if.evt_id_o, 3);
        check("lat_pend_ho", pend, 8'h00);
        evt_if.evt_ready_i = 1'b1; tick(1); evt_if.evt_ready_i = 1'b0;
        check("lat_drain", evt_if.evt_valid_o, 0);
        // NEG / ANY / LEVEL on ch0..2, masked so nothing is handed out
        sig = 8'hF8; tick(5);
        mode = 16'h0039; mask = 8'h07; tick(2);
        sig = 8'hFF; tick(3);
        check("mode_pend_rise", pend, 8'h06);
        check("mode_ovf_rise", ovf, 8'h00);
        tick(1);
        sig = 8'hF8; tick(8);
        check("mode_pend", pend, 8'h07);
        check("mode_ovf", ovf, 8'h06);
        check("mode_irq", irq, 0);
        check("mode_valid", evt_if.evt_valid_o, 0);
        // priority handout and hold
        clr = 8'h07; tick(1); clr = 8'h00;
        check("clr_pend", pend, 8'h00);
        check("clr_ovf", ovf, 8'h00);
        mode = 16'h0008; mask = 8'hFF; sig = 8'hD8; tick(5);
        sig = 8'hFE; tick(4);
        check("prio_pend", pend, 8'h26);
        mask = 8'h00; tick(1);
        check("prio_valid", evt_if.evt_valid_o, 1);
        check("prio_id1", evt_if.evt_id_o, 1);
        check("prio_pend_ho", pend, 8'h24);
        sig = 8'hFF; tick(5);
        check("hold_id", evt_if.evt_id_o, 1);
        check("hold_pend", pend, 8'h25);
        check("hold_irq", irq, 1);
        evt_if.evt_ready_i = 1'b1; tick(1);
        check("b2b_id0", evt_if.evt_id_o, 0);
        tick(1);
        check("b2b_id2", evt_if.evt_id_o, 2);
        tick(1);
        check("b2b_id5", evt_if.evt_id_o, 5);
        check("b2b_pend", pend, 8'h00);
        tick(1);
        check("b2b_empty", evt_if.evt_valid_o, 0);
        // masked channel
        mask = 8'h10; sig = 8'hEF; tick(5);
        sig = 8'hFF; tick(5);
        check("mask_pend", pend, 8'h10);
        check("mask_irq", irq, 0);
        check("mask_valid", evt_if.evt_valid_o, 0);
        mask = 8'h00; tick(1);
        check("unmask_irq", irq, 1);
        check("unmask_valid", evt_if.evt_valid_o, 1);
        check("unmask_id", evt_if.evt_id_o, 4);
        tick(1);
        check("unmask_drain", evt_if.evt_valid_o, 0);
        check("unmask_irq_off", irq, 0);
        // clear colliding with a new detect
        mask = 8'h04; sig = 8'hFB; tick(5);
        sig = 8'hFF; tick(5);
        check("coll_pend0", pend, 8'h04);
        sig = 8'hFB; tick(5);
        sig = 8'hFF; tick(2);
        clr = 8'h04; tick(1); clr = 8'h00;
        check("coll_pend", pend, 8'h04);
        check("coll_ovf", ovf, 8'h04);
        clr = 8'h04; tick(1); clr = 8'h00;
        check("coll_clr_pend", pend, 8'h00);
        check("coll_clr_ovf", ovf, 8'h00);
        // async reset mid-handshake
        mask = 8'h0F; evt_if.evt_ready_i = 1'b0; sig = 8'hE0; tick(5);
        sig = 8'hFF; tick(5);
        check("mid_pend", pend, 8'h0F);
        check("mid_valid", evt_if.evt_valid_o, 1);
        check("mid_id", evt_if.evt_id_o, 4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pend", pend, 8'h00);
        check("arst_ovf", ovf, 8'h00);
        check("arst_irq", irq, 0);
        check("arst_valid", evt_if.evt_valid_o, 0);
        check("arst_id", evt_if.evt_id_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(12);
        check("post_pend", pend, 8'h00);
        check("post_valid", evt_if.evt_valid_o, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
